rng_arbiter: RTL
================

Name: rng_arbiter

Overview:
Owns the design's single 8-bit pseudo-random source and shares it among NUM_REQ requesters, such as game-logic timers and pattern generators. It holds the LFSR state internally and handles seeding and a warm-up period after each seed. It then grants random bytes round-robin, one requester per cycle, so that no two grants ever carry the same LFSR state.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEED_DEFAULT, 8'hA5, LFSR value loaded at reset; also replaces an illegal seed
WARMUP, 8, LFSR steps after reset or seed load before any grant (0..255; 0 = serve immediately)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
seed_load  input  1  one-cycle pulse; load seed into LFSR
seed  input  8  seed value, sampled when seed_load=1
req  input  NUM_REQ  level request per requester; held until granted
gnt  output  NUM_REQ  one-hot, one-cycle grant pulse (registered)
rnd_data  output  8  random byte, valid while rnd_valid=1
rnd_valid  output  1  high in exactly the cycles where gnt != 0
busy  output  1  high while in WARMUP

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state is on the posedge of clk.
- Reset values:
  - lfsr = SEED_DEFAULT, state = WARMUP (SERVE if WARMUP=0), warm_cnt = 0, rr_ptr = 0.
  - gnt = 0, rnd_data = 8'h00, rnd_valid = 0, busy = (WARMUP != 0).
- LFSR step:
  - lfsr <= {lfsr[6:0], fb}, where fb = lfsr[7] ~^ lfsr[5] ~^ lfsr[4] ~^ lfsr[3], evaluated left to right.
  - This equals the inverted parity of the four taps.
  - The LFSR steps on every clock in both states, except the cycle seed_load is taken.
  - 8'hFF is the lock-up state and must never be loaded.
- WARMUP state:
  - busy=1; requests are ignored (not dropped; requesters keep req high).
  - warm_cnt increments each cycle; when warm_cnt == WARMUP-1, go to SERVE and clear warm_cnt.
- SERVE state:
  - busy=0. If any req bit is high, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: gnt = one-hot(winner), rnd_data = lfsr value before that edge, rnd_valid = 1, rr_ptr = (winner+1) mod NUM_REQ.
  - Latency from req sampled high (uncontested) to gnt is 1 cycle.
  - With no request: gnt = 0, rnd_valid = 0, rnd_data holds its last value, and rr_ptr is unchanged.
- Requester protocol:
  - A requester must deassert req in the cycle it sees gnt; a req still high is treated as a new request.
  - A lone continuous requester is granted every cycle, each time with a distinct value.
  - With all requesters active, each one is granted once every NUM_REQ cycles (starvation-free).
- seed_load (highest priority, any state):
  - lfsr <= (seed == 8'hFF) ? SEED_DEFAULT : seed.
  - state <= WARMUP (SERVE if WARMUP=0), warm_cnt <= 0.
  - gnt/rnd_valid are 0 on the following cycle, and any pending arbitration is discarded.
  - rr_ptr is unchanged.
- Reset mid-grant: outputs clear immediately (asynchronous); no partial grant survives.

Optional Feature:
Macro RNG_GRANT_COUNT_EN.
- Defined:
  - Adds output grant_count [NUM_REQ*8-1:0]: one 8-bit counter per requester, at bits [i*8+7:i*8].
  - The counter increments when that requester's gnt pulses and saturates at 8'hFF.
  - All counters clear on reset and on seed_load.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
1. WARMUP=0, reset released, req=4'b0100 held 1 cycle -> next cycle gnt=4'b0100, rnd_data=8'hA5; the following grant to any requester gives 8'h4B, then 8'h96 if granted back-to-back.
2. WARMUP=8, req=4'b0001 high from reset release -> busy=1 for 8 cycles, gnt=0 throughout; first gnt appears 1 cycle after busy falls.
3. WARMUP=0, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with no repeated rnd_data.
4. seed_load=1, seed=8'h3C, during active grants -> next cycle gnt=0, busy=1 (WARMUP=8); with WARMUP=0, the first subsequent grant shows rnd_data=8'h3C.
5. seed_load with seed=8'hFF -> LFSR holds 8'hA5, confirmed by the first grant value (WARMUP=0).
6. Asynchronous reset asserted mid-cycle while gnt=4'b0010 -> gnt, rnd_valid, rnd_data clear without waiting for a clock edge. With RNG_GRANT_COUNT_EN defined: 300 grants to requester 0 -> grant_count[7:0]=8'hFF.

Source files
------------

// File: rtl/rng_arbiter_if.sv
// Request/grant bundle between the shared LFSR arbiter and its requesters.
// Carries grant_count only when RNG_GRANT_COUNT_EN is defined.
interface rng_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic               seed_load;
    logic [7:0]         seed;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [7:0]         rnd_data;
    logic               rnd_valid;
    logic               busy;
`ifdef RNG_GRANT_COUNT_EN
    logic [NUM_REQ*8-1:0] grant_count;
`endif

    modport master (
        output seed_load, seed, req,
`ifdef RNG_GRANT_COUNT_EN
        input  grant_count,
`endif
        input  gnt, rnd_data, rnd_valid, busy
    );

    modport slave (
        input  seed_load, seed, req,
`ifdef RNG_GRANT_COUNT_EN
        output grant_count,
`endif
        output gnt, rnd_data, rnd_valid, busy
    );
endinterface

// File: rtl/rng_arbiter.sv
// Shared 8-bit XNOR LFSR handed out round-robin to NUM_REQ requesters, with seeding and warm-up.
// Optional per-requester saturating grant counters under RNG_GRANT_COUNT_EN.
module rng_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic [7:0]  SEED_DEFAULT = 8'hA5,
    parameter int unsigned WARMUP       = 8
) (
    input logic          clk,
    input logic          reset,
    rng_arbiter_if.slave bus
);
    localparam int unsigned PtrW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  WarmLast  = 8'((WARMUP == 0) ? 0 : WARMUP - 1);
    localparam logic        BusyStart = (WARMUP != 0);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [0:0] {StWarmup, StServe} state_e;
    localparam state_e StStart = (WARMUP == 0) ? StServe : StWarmup;

    state_e             state_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_next;
    logic [7:0]         warm_cnt_q;
    logic [PtrW-1:0]    rr_ptr_q;
    logic [PtrW-1:0]    winner;
    logic [PtrW-1:0]    winner_next;
    logic [PtrW-1:0]    idx;
    logic               found;
    logic [NUM_REQ-1:0] gnt_q;
    logic [7:0]         rnd_data_q;
    logic               rnd_valid_q;
    logic               busy_q;
    logic [7:0]         seed_safe;

    // Inverted parity of taps 7,5,4,3; all-ones is the lock-up state.
    assign lfsr_next = {lfsr_q[6:0], ~^{lfsr_q[7], lfsr_q[5], lfsr_q[4], lfsr_q[3]}};
    assign seed_safe = (bus.seed == 8'hFF) ? SEED_DEFAULT : bus.seed;

    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        winner_next = (winner == PtrW'(NUM_REQ - 1)) ? '0 : winner + PtrW'(1);
    end

`ifdef RNG_GRANT_COUNT_EN
    logic [7:0] cnt_q [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_out
        assign bus.grant_count[i*8 +: 8] = cnt_q[i];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StStart;
            lfsr_q      <= SEED_DEFAULT;
            warm_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rnd_data_q  <= 8'h00;
            rnd_valid_q <= 1'b0;
            busy_q      <= BusyStart;
`ifdef RNG_GRANT_COUNT_EN
            cnt_q       <= '{default: '0};
`endif
        end else if (bus.seed_load) begin
            // Reseed wins over everything; pending arbitration is dropped, rr_ptr kept.
            state_q     <= StStart;
            lfsr_q      <= seed_safe;
            warm_cnt_q  <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            busy_q      <= BusyStart;
`ifdef RNG_GRANT_COUNT_EN
            cnt_q       <= '{default: '0};
`endif
        end else begin
            lfsr_q      <= lfsr_next;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            unique case (state_q)
                StWarmup: begin
                    if (warm_cnt_q == WarmLast) begin
                        state_q    <= StServe;
                        warm_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + 8'd1;
                    end
                end
                StServe: begin
                    if (found) begin
                        gnt_q       <= OneHot0 << winner;
                        rnd_data_q  <= lfsr_q;
                        rnd_valid_q <= 1'b1;
                        rr_ptr_q    <= winner_next;
`ifdef RNG_GRANT_COUNT_EN
                        if (cnt_q[winner] != 8'hFF) begin
                            cnt_q[winner] <= cnt_q[winner] + 8'd1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_data  = rnd_data_q;
    assign bus.rnd_valid = rnd_valid_q;
    assign bus.busy      = busy_q;
endmodule
